// File: rtl/d_trig_reg_arbiter.sv
// Round-robin write arbiter feeding one shared clear-value register.
// A locked owner keeps the register for up to MAX_HOLD grant cycles before forced eviction.
module d_trig_reg_arbiter #(
    parameter int                NREQ      = 4,
    parameter int                WIDTH     = 8,
    parameter logic [WIDTH-1:0]  CLEAR_VAL = 8'hA5,
    parameter int                MAX_HOLD  = 4
) (
    input  logic                     C,
    input  logic                     CLR,
    input  logic [NREQ-1:0]          req,
    input  logic [NREQ-1:0]          lock,
    input  logic [NREQ*WIDTH-1:0]    data,
    input  logic                     sclr,
    output logic [NREQ-1:0]          gnt,
    output logic [$clog2(NREQ)-1:0]  owner,
    output logic                     busy,
    output logic                     evict,
    output logic [WIDTH-1:0]         Q,
    output logic [WIDTH-1:0]         notQ
);

    localparam int OW = $clog2(NREQ);
    localparam int HW = $clog2(MAX_HOLD + 1);

    typedef enum logic {IDLE, OWN} state_t;

    state_t            state_q, state_d;
    logic [NREQ-1:0]   gnt_q, gnt_d;
    logic [OW-1:0]     owner_q, owner_d;
    logic [OW-1:0]     ptr_q, ptr_d;
    logic [HW-1:0]     hold_q, hold_d;
    logic              busy_q, busy_d;
    logic              evict_q, evict_d;
    logic [WIDTH-1:0]  q_q, q_d;

    logic [WIDTH-1:0]  data_arr [NREQ];
    logic              found;
    logic [OW-1:0]     win;
    logic [OW-1:0]     cand;
    int                idx;

    for (genvar i = 0; i < NREQ; i++) begin : g_unpack
        assign data_arr[i] = data[i*WIDTH +: WIDTH];
    end

    // Search starts at ptr and wraps with an explicit compare so non-power-of-2 NREQ works.
    always_comb begin
        found = 1'b0;
        win   = '0;
        cand  = '0;
        idx   = 0;
        for (int k = 0; k < NREQ; k++) begin
            idx = int'(ptr_q) + k;
            if (idx >= NREQ) idx = idx - NREQ;
            cand = OW'(idx);
            if (!found && req[cand]) begin
                found = 1'b1;
                win   = cand;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        owner_d = owner_q;
        ptr_d   = ptr_q;
        hold_d  = hold_q;
        busy_d  = busy_q;
        evict_d = 1'b0;
        q_d     = q_q;
        case (state_q)
            IDLE: begin
                if (sclr) begin
                    q_d   = CLEAR_VAL;
                    gnt_d = '0;
                end else if (found) begin
                    gnt_d      = '0;
                    gnt_d[win] = 1'b1;
                    owner_d    = win;
                    q_d        = data_arr[win];
                    ptr_d      = (win == OW'(NREQ - 1)) ? '0 : win + OW'(1);
                    if (lock[win]) begin
                        state_d = OWN;
                        hold_d  = HW'(1);
                        busy_d  = 1'b1;
                    end
                end else begin
                    gnt_d = '0;
                end
            end
            OWN: begin
                if (sclr) begin
                    q_d     = CLEAR_VAL;
                    gnt_d   = '0;
                    busy_d  = 1'b0;
                    hold_d  = '0;
                    state_d = IDLE;
                end else if (!lock[owner_q] || !req[owner_q]) begin
                    gnt_d   = '0;
                    busy_d  = 1'b0;
                    hold_d  = '0;
                    state_d = IDLE;
                end else if (hold_q == HW'(MAX_HOLD)) begin
                    gnt_d   = '0;
                    busy_d  = 1'b0;
                    evict_d = 1'b1;
                    hold_d  = '0;
                    state_d = IDLE;
                end else begin
                    q_d    = data_arr[owner_q];
                    hold_d = hold_q + HW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge C or posedge CLR) begin
        if (CLR) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            owner_q <= '0;
            ptr_q   <= '0;
            hold_q  <= '0;
            busy_q  <= 1'b0;
            evict_q <= 1'b0;
            q_q     <= CLEAR_VAL;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            owner_q <= owner_d;
            ptr_q   <= ptr_d;
            hold_q  <= hold_d;
            busy_q  <= busy_d;
            evict_q <= evict_d;
            q_q     <= q_d;
        end
    end

    assign gnt   = gnt_q;
    assign owner = owner_q;
    assign busy  = busy_q;
    assign evict = evict_q;
    assign Q     = q_q;
    assign notQ  = ~q_q;

endmodule
